// File: rtl/icache_pkg.sv
// Shared state type, derived-geometry helpers and word extraction for the N-way I-cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} icache_state_t;

  localparam int MAX_LINE_BITS = 1024;

  function automatic int sets_f(input int cache_size, input int line_bits, input int ways);
    return (cache_size * 8) / (line_bits * ways);
  endfunction

  function automatic int off_w_f(input int line_bits);
    return $clog2(line_bits / 32);
  endfunction

  function automatic int idx_w_f(input int cache_size, input int line_bits, input int ways);
    return $clog2(sets_f(cache_size, line_bits, ways));
  endfunction

  function automatic int tag_w_f(input int addr_w, input int cache_size, input int line_bits,
                                 input int ways);
    return addr_w - idx_w_f(cache_size, line_bits, ways) - off_w_f(line_bits) - 2;
  endfunction

  function automatic int way_w_f(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Lines narrower than MAX_LINE_BITS are zero-extended by the caller.
  function automatic logic [31:0] word_sel(input logic [MAX_LINE_BITS-1:0] line,
                                           input logic [31:0] word);
    return 32'(line >> (word * 32));
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state with one update port and one victim read port.
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_upd_en,
  input  logic [$clog2(SETS)-1:0]  i_upd_set,
  input  logic [way_w_f(WAYS)-1:0] i_upd_way,
  input  logic [$clog2(SETS)-1:0]  i_vic_set,
  output logic [way_w_f(WAYS)-1:0] o_vic_way
);

  generate
    if (WAYS == 1) begin : g_direct
      assign o_vic_way = '0;
      wire w_unused = ^{clk, rst, i_upd_en, i_upd_set, i_upd_way, i_vic_set};
    end else begin : g_tree
      localparam int LVL = $clog2(WAYS);

      logic [WAYS-2:0] r_bits [SETS];
      logic [WAYS-2:0] w_upd_bits;
      logic [WAYS-2:0] w_vic_bits;

      // Heap-ordered tree; each node bit points at the less recently used half.
      always_comb begin
        int node;
        node       = 0;
        w_upd_bits = r_bits[i_upd_set];
        for (int l = 0; l < LVL; l++) begin
          w_upd_bits[node] = ~i_upd_way[LVL-1-l];
          node = 2 * node + 1 + int'(i_upd_way[LVL-1-l]);
        end
      end

      always_comb begin
        int node;
        node       = 0;
        w_vic_bits = r_bits[i_vic_set];
        o_vic_way  = '0;
        for (int l = 0; l < LVL; l++) begin
          o_vic_way[LVL-1-l] = w_vic_bits[node];
          node = 2 * node + 1 + int'(w_vic_bits[node]);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
        end else if (i_upd_en) begin
          r_bits[i_upd_set] <= w_upd_bits;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache: first-invalid/tree-PLRU replacement,
// critical-word bypass on refill, whole-cache flush and saturating hit/miss counters.
module icache_nway
  import icache_pkg::*;
#(
  parameter int CACHE_SIZE = 8192,
  parameter int LINE_BITS  = 128,
  parameter int WAYS       = 2,
  parameter int ADDR_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cpu_req_valid,
  output logic                 o_cpu_req_ready,
  input  logic [ADDR_W-1:0]    i_cpu_addr,
  output logic                 o_cpu_rsp_valid,
  output logic [31:0]          o_cpu_rsp_data,
  output logic                 o_cpu_rsp_hit,
  input  logic                 i_flush,
  output logic                 o_mem_req,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic                 i_mem_ready,
  input  logic [LINE_BITS-1:0] i_mem_data_in,
  output logic [31:0]          o_hit_cnt,
  output logic [31:0]          o_miss_cnt
);

  localparam int SETS  = sets_f(CACHE_SIZE, LINE_BITS, WAYS);
  localparam int OFF_W = off_w_f(LINE_BITS);
  localparam int IDX_W = idx_w_f(CACHE_SIZE, LINE_BITS, WAYS);
  localparam int TAG_W = tag_w_f(ADDR_W, CACHE_SIZE, LINE_BITS, WAYS);
  localparam int WAY_W = way_w_f(WAYS);
  localparam int WORDS = LINE_BITS / 32;

  icache_state_t        r_state, w_next;
  logic [ADDR_W-1:0]    r_addr;
  logic [WAY_W-1:0]     r_victim;
  logic                 r_flush_pend;
  logic [31:0]          r_hit_cnt, r_miss_cnt, r_last_data;
  logic                 r_valid [WAYS][SETS];
  logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
  logic [LINE_BITS-1:0] r_data  [WAYS][SETS];

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [31:0]          w_word, w_rsp_word;
  logic [ADDR_W-1:0]    w_line_addr;
  logic                 w_hit, w_free;
  logic [WAY_W-1:0]     w_hit_way, w_free_way, w_plru_way, w_fill_way;
  logic                 w_accept, w_flush_now, w_lookup_hit, w_lookup_miss, w_install;
  logic [LINE_BITS-1:0] w_rsp_line;

  assign w_idx       = IDX_W'(r_addr >> (OFF_W + 2));
  assign w_tag       = TAG_W'(r_addr >> (OFF_W + IDX_W + 2));
  assign w_word      = 32'(r_addr >> 2) & 32'(WORDS - 1);
  assign w_line_addr = r_addr & ~ADDR_W'(LINE_BITS / 8 - 1);

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w][w_idx]) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  assign w_fill_way  = w_free ? w_free_way : w_plru_way;
  assign w_rsp_line  = (r_state == LOOKUP) ? r_data[w_hit_way][w_idx] : i_mem_data_in;
  assign w_rsp_word  = word_sel(MAX_LINE_BITS'(w_rsp_line), w_word);
  assign w_accept    = i_cpu_req_valid & o_cpu_req_ready;
  assign w_flush_now = (r_state == IDLE) & (i_flush | r_flush_pend);

  icache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk       (clk),
    .rst       (rst),
    .i_upd_en  (w_lookup_hit | w_install),
    .i_upd_set (w_idx),
    .i_upd_way (w_install ? r_victim : w_hit_way),
    .i_vic_set (w_idx),
    .o_vic_way (w_plru_way)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LOOKUP;
      LOOKUP:  w_next = w_hit ? IDLE : REFILL;
      REFILL:  if (i_mem_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_cpu_req_ready = 1'b0;
    o_mem_req       = 1'b0;
    o_cpu_rsp_valid = 1'b0;
    o_cpu_rsp_hit   = 1'b0;
    w_lookup_hit    = 1'b0;
    w_lookup_miss   = 1'b0;
    w_install       = 1'b0;
    case (r_state)
      IDLE:   o_cpu_req_ready = ~i_flush & ~r_flush_pend;
      LOOKUP: begin
        o_cpu_rsp_valid = w_hit;
        o_cpu_rsp_hit   = w_hit;
        w_lookup_hit    = w_hit;
        w_lookup_miss   = ~w_hit;
      end
      REFILL: begin
        o_mem_req       = 1'b1;
        o_cpu_rsp_valid = i_mem_ready;
        w_install       = i_mem_ready;
      end
      default: ;
    endcase
  end

  assign o_mem_addr     = o_mem_req ? w_line_addr : '0;
  assign o_cpu_rsp_data = o_cpu_rsp_valid ? w_rsp_word : r_last_data;
  assign o_hit_cnt      = r_hit_cnt;
  assign o_miss_cnt     = r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_victim     <= '0;
      r_flush_pend <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_last_data  <= '0;
    end else begin
      if (w_accept)        r_addr <= i_cpu_addr;
      if (w_lookup_miss)   r_victim <= w_fill_way;
      if (w_flush_now)     r_flush_pend <= 1'b0;
      else if (i_flush)    r_flush_pend <= 1'b1;
      if (w_lookup_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_lookup_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
      if (o_cpu_rsp_valid) r_last_data <= w_rsp_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) r_valid[w][s] <= 1'b0;
    end else if (w_flush_now) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) r_valid[w][s] <= 1'b0;
    end else if (w_install) begin
      r_valid[r_victim][w_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tag[r_victim][w_idx]  <= w_tag;
      r_data[r_victim][w_idx] <= i_mem_data_in;
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (2 ways, 32 sets, 128-bit lines) with hand-computed expectations.
module tb_icache_nway;

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] LINE_C = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  localparam logic [127:0] LINE_D = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
  localparam logic [127:0] LINE_E = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
  localparam logic [127:0] JUNK   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpuReqValid = 1'b0;
  logic         cpuReqReady;
  logic [31:0]  cpuAddr = '0;
  logic         cpuRspValid;
  logic [31:0]  cpuRspData;
  logic         cpuRspHit;
  logic         flush = 1'b0;
  logic         memReq;
  logic [31:0]  memAddr;
  logic         memReady = 1'b0;
  logic [127:0] memDataIn = '0;
  logic [31:0]  hitCnt, missCnt;

  int vectors     = 0;
  int miscompares = 0;

  icache_nway #(.CACHE_SIZE(1024), .LINE_BITS(128), .WAYS(2), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cpu_req_valid (cpuReqValid),
    .o_cpu_req_ready (cpuReqReady),
    .i_cpu_addr      (cpuAddr),
    .o_cpu_rsp_valid (cpuRspValid),
    .o_cpu_rsp_data  (cpuRspData),
    .o_cpu_rsp_hit   (cpuRspHit),
    .i_flush         (flush),
    .o_mem_req       (memReq),
    .o_mem_addr      (memAddr),
    .i_mem_ready     (memReady),
    .i_mem_data_in   (memDataIn),
    .o_hit_cnt       (hitCnt),
    .o_miss_cnt      (missCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic f,
                               input logic mr, input logic [127:0] line);
    @(negedge clk);
    cpuReqValid = v;
    cpuAddr     = a;
    flush       = f;
    memReady    = mr;
    memDataIn   = line;
    #1;
  endtask

  task automatic doHit(input logic [31:0] addr, input logic [31:0] expWord, input logic stray,
                       input int expHit);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, '0);
    checkOutput("hit.accept_ready", 32'(cpuReqReady), 1);
    applyStimulus(1'b0, addr, 1'b0, stray, JUNK);
    checkOutput("hit.rsp_valid", 32'(cpuRspValid), 1);
    checkOutput("hit.rsp_hit", 32'(cpuRspHit), 1);
    checkOutput("hit.rsp_data", cpuRspData, expWord);
    checkOutput("hit.no_mem_req", 32'(memReq), 0);
    checkOutput("hit.busy_ready", 32'(cpuReqReady), 0);
    applyStimulus(1'b0, addr, 1'b0, 1'b0, '0);
    checkOutput("hit.rsp_done", 32'(cpuRspValid), 0);
    checkOutput("hit.hit_cnt", hitCnt, 32'(expHit));
    checkOutput("hit.idle_ready", 32'(cpuReqReady), 1);
  endtask

  task automatic doMiss(input logic [31:0] addr, input logic [127:0] line,
                        input logic [31:0] expWord, input logic [31:0] expMemAddr, input int gap,
                        input int flushAt, input logic holdValid, input int expMiss);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, '0);
    checkOutput("miss.accept_ready", 32'(cpuReqReady), 1);
    applyStimulus(holdValid, addr, 1'b0, 1'b0, '0);
    checkOutput("miss.lookup_rsp", 32'(cpuRspValid), 0);
    checkOutput("miss.lookup_mem_req", 32'(memReq), 0);
    checkOutput("miss.lookup_ready", 32'(cpuReqReady), 0);
    for (int i = 0; i < gap; i++) begin
      applyStimulus(holdValid, addr, 1'(flushAt == i), 1'b0, '0);
      checkOutput("miss.mem_req", 32'(memReq), 1);
      checkOutput("miss.mem_addr", memAddr, expMemAddr);
      checkOutput("miss.refill_ready", 32'(cpuReqReady), 0);
      checkOutput("miss.early_rsp", 32'(cpuRspValid), 0);
      if (i == 0) checkOutput("miss.miss_cnt", missCnt, 32'(expMiss));
    end
    applyStimulus(holdValid, addr, 1'b0, 1'b1, line);
    checkOutput("miss.rsp_valid", 32'(cpuRspValid), 1);
    checkOutput("miss.rsp_hit", 32'(cpuRspHit), 0);
    checkOutput("miss.rsp_data", cpuRspData, expWord);
    checkOutput("miss.mem_addr_final", memAddr, expMemAddr);
    applyStimulus(1'b0, addr, 1'b0, 1'b0, '0);
    checkOutput("miss.mem_req_drop", 32'(memReq), 0);
    checkOutput("miss.rsp_done", 32'(cpuRspValid), 0);
    checkOutput("miss.rsp_hold", cpuRspData, expWord);
    checkOutput("miss.post_ready", 32'(cpuReqReady), (flushAt >= 0) ? 0 : 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.mem_req", 32'(memReq), 0);
    checkOutput("reset.mem_addr", memAddr, 0);
    checkOutput("reset.rsp_valid", 32'(cpuRspValid), 0);
    checkOutput("reset.rsp_hit", 32'(cpuRspHit), 0);
    checkOutput("reset.rsp_data", cpuRspData, 0);
    checkOutput("reset.hit_cnt", hitCnt, 0);
    checkOutput("reset.miss_cnt", missCnt, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset.ready_after", 32'(cpuReqReady), 1);

    doMiss(32'h1004, LINE_A, 32'h22222222, 32'h1000, 1, -1, 1'b0, 1);
    doHit(32'h1004, 32'h22222222, 1'b0, 1);
    doHit(32'h100C, 32'h44444444, 1'b0, 2);

    doMiss(32'h3000, LINE_B, 32'hBBBB0000, 32'h3000, 2, -1, 1'b0, 2);
    doHit(32'h1000, 32'h11111111, 1'b0, 3);
    doMiss(32'h5004, LINE_C, 32'hCCCC0001, 32'h5000, 1, -1, 1'b0, 3);
    doHit(32'h1008, 32'h33333333, 1'b0, 4);
    doMiss(32'h3000, LINE_B, 32'hBBBB0000, 32'h3000, 1, -1, 1'b0, 4);

    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, '0);
    checkOutput("flush.idle_ready", 32'(cpuReqReady), 0);
    applyStimulus(1'b0, 32'h1000, 1'b0, 1'b0, '0);
    checkOutput("flush.not_accepted", 32'(cpuReqReady), 1);
    checkOutput("flush.no_rsp", 32'(cpuRspValid), 0);
    doMiss(32'h1000, LINE_A, 32'h11111111, 32'h1000, 1, -1, 1'b0, 5);

    doMiss(32'h7000, LINE_D, 32'hDDDD0000, 32'h7000, 3, 1, 1'b0, 6);
    doMiss(32'h7008, LINE_D, 32'hDDDD0002, 32'h7000, 1, -1, 1'b0, 7);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, JUNK);
    checkOutput("stray.idle_rsp", 32'(cpuRspValid), 0);
    checkOutput("stray.idle_mem_req", 32'(memReq), 0);
    doHit(32'h7000, 32'hDDDD0000, 1'b1, 5);
    doHit(32'h7004, 32'hDDDD0001, 1'b0, 6);
    doMiss(32'h9004, LINE_E, 32'hEEEE0001, 32'h9000, 2, -1, 1'b1, 8);

    applyStimulus(1'b1, 32'hB000, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 32'hB000, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 32'hB000, 1'b0, 1'b0, '0);
    checkOutput("rstmid.mem_req_before", 32'(memReq), 1);
    rst       = 1'b0;
    memReady  = 1'b1;
    memDataIn = LINE_A;
    #1;
    checkOutput("rstmid.mem_req", 32'(memReq), 0);
    checkOutput("rstmid.rsp_valid", 32'(cpuRspValid), 0);
    checkOutput("rstmid.miss_cnt", missCnt, 0);
    checkOutput("rstmid.hit_cnt", hitCnt, 0);
    @(negedge clk);
    rst      = 1'b1;
    memReady = 1'b0;
    doMiss(32'h7000, LINE_D, 32'hDDDD0000, 32'h7000, 1, -1, 1'b0, 1);
    doMiss(32'h9000, LINE_E, 32'hEEEE0000, 32'h9000, 1, -1, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
